// File: rtl/vending_fsm_pkg.sv
// Shared types and constants for the drink vending controller.
// States, coin values, button codes and the legal-coin check.
package vending_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELIVER = 2'd1,
      CHANGE  = 2'd2
   } state_t;

   localparam logic [7:0] COIN_10  = 8'd10;
   localparam logic [7:0] COIN_20  = 8'd20;
   localparam logic [7:0] COIN_50  = 8'd50;
   localparam logic [7:0] COIN_100 = 8'd100;
   localparam logic [7:0] COIN_200 = 8'd200;

   localparam logic [1:0] BTN_NONE  = 2'd0;
   localparam logic [1:0] BTN_WATER = 2'd1;
   localparam logic [1:0] BTN_SODA  = 2'd2;

   function automatic logic is_valid_coin(logic [7:0] c);
      return (c == COIN_10)  || (c == COIN_20)  ||
             (c == COIN_50)  || (c == COIN_100) ||
             (c == COIN_200);
   endfunction

endpackage

// File: rtl/vending_fsm_if.sv
// Front-end / actuator bundle of the vending controller.
// master drives coins and buttons, slave is the controller.
interface vending_fsm_if;

   logic [7:0] coin_in;
   logic [1:0] button_in;
   logic [7:0] change_out;
   logic [1:0] beverage_out;
   logic [7:0] credit;
   logic [1:0] state;

   modport master (
      output coin_in,
      output button_in,
      input  change_out,
      input  beverage_out,
      input  credit,
      input  state
   );

   modport slave (
      input  coin_in,
      input  button_in,
      output change_out,
      output beverage_out,
      output credit,
      output state
   );

endinterface

// File: rtl/vending_fsm_phase_timer.sv
// Loadable 8-bit down-counter timing the DELIVER and CHANGE phases.
// last is high while the count sits at zero.
module vend_phase_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       last
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 8'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != 8'd0) begin
         cnt <= cnt - 8'd1;
      end
   end

   assign last = (cnt == 8'd0);

endmodule

// File: rtl/vending_fsm.sv
// Drink vending controller: coin credit, purchase, delivery, change.
// All outputs come straight from registers.
module vending_fsm
   import vending_pkg::*;
#(
   parameter int unsigned N           = 3,
   parameter int unsigned M           = 2,
   parameter int unsigned PRICE_WATER = 50,
   parameter int unsigned PRICE_SODA  = 100
) (
   input  logic         clk,
   input  logic         rst,
   vending_fsm_if.slave bus
);

   localparam logic [7:0] N_LAST  = 8'(N - 1);
   localparam logic [7:0] M_LAST  = 8'(M - 1);
   localparam logic [7:0] P_WATER = 8'(PRICE_WATER);
   localparam logic [7:0] P_SODA  = 8'(PRICE_SODA);

   state_t     state_q;
   logic [7:0] credit_q;
   logic [1:0] sel_q;
   logic [1:0] bev_q;
   logic [7:0] chg_q;

   logic       last;
   logic       buy;
   logic       coin_ok;
   logic [8:0] sum;
   logic [7:0] price;
   logic       tmr_load;
   logic [7:0] tmr_val;

   always_comb begin
      price   = P_WATER;
      buy     = 1'b0;
      coin_ok = 1'b0;
      sum     = {1'b0, credit_q} + {1'b0, bus.coin_in};
      unique case (1'b1)
         (bus.button_in == BTN_SODA):  price = P_SODA;
         (bus.button_in == BTN_WATER): price = P_WATER;
         default:                      price = P_WATER;
      endcase
      if (state_q == IDLE) begin
         if (bus.coin_in != 8'd0) begin
            coin_ok = is_valid_coin(bus.coin_in) && !sum[8];
         end else if ((bus.button_in == BTN_WATER ||
                       bus.button_in == BTN_SODA) &&
                      credit_q >= price) begin
            buy = 1'b1;
         end
      end
   end

   // One timer serves both phases; reloaded on each phase entry.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = N_LAST;
      if (buy) begin
         tmr_load = 1'b1;
         tmr_val  = N_LAST;
      end else if (state_q == DELIVER && last &&
                   credit_q != 8'd0) begin
         tmr_load = 1'b1;
         tmr_val  = M_LAST;
      end
   end

   vend_phase_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .last     (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         credit_q <= 8'd0;
         sel_q    <= BTN_NONE;
         bev_q    <= 2'd0;
         chg_q    <= 8'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (coin_ok) begin
                  credit_q <= sum[7:0];
               end else if (buy) begin
                  sel_q    <= bus.button_in;
                  bev_q    <= bus.button_in;
                  credit_q <= credit_q - price;
                  state_q  <= DELIVER;
               end
            end
            DELIVER: begin
               if (last) begin
                  bev_q <= 2'd0;
                  if (credit_q != 8'd0) begin
                     chg_q   <= credit_q;
                     state_q <= CHANGE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            CHANGE: begin
               if (last) begin
                  credit_q <= 8'd0;
                  chg_q    <= 8'd0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               bev_q   <= 2'd0;
               chg_q   <= 8'd0;
            end
         endcase
      end
   end

   assign bus.beverage_out = bev_q;
   assign bus.change_out   = chg_q;
   assign bus.credit       = credit_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_vending_fsm.sv
// Directed scoreboard bench for vending_fsm.
// Each step queues its expected outputs and checks them after the edge.
module tb_vending_fsm;

   typedef struct {
      logic [7:0] credit;
      logic [1:0] state;
      logic [7:0] chg;
      logic [1:0] bev;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   vending_fsm_if bus ();

   vending_fsm #(
      .N           (3),
      .M           (2),
      .PRICE_WATER (50),
      .PRICE_SODA  (100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic       r,
                       input logic [7:0] coin,
                       input logic [1:0] btn,
                       input logic [7:0] e_credit,
                       input logic [1:0] e_state,
                       input logic [7:0] e_chg,
                       input logic [1:0] e_bev);
      exp_t e;
      exp_t o;
      rst           = r;
      bus.coin_in   = coin;
      bus.button_in = btn;
      e.credit = e_credit;
      e.state  = e_state;
      e.chg    = e_chg;
      e.bev    = e_bev;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      chk("credit", bus.credit, o.credit);
      chk("state", {6'd0, bus.state}, {6'd0, o.state});
      chk("change_out", bus.change_out, o.chg);
      chk("beverage_out", {6'd0, bus.beverage_out}, {6'd0, o.bev});
   endtask

   initial begin
      bus.coin_in   = 8'd0;
      bus.button_in = 2'd0;
      // reset with a coin present
      step(1, 50, 0, 0, 0, 0, 0);
      step(1, 50, 0, 0, 0, 0, 0);
      // exact payment, water
      step(0, 50, 0, 50, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      // soda with change
      step(0, 200, 0, 200, 0, 0, 0);
      step(0, 0, 2, 100, 1, 0, 2);
      step(0, 0, 0, 100, 1, 0, 2);
      step(0, 0, 0, 100, 1, 0, 2);
      step(0, 0, 0, 100, 2, 100, 0);
      step(0, 0, 0, 100, 2, 100, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      // rejections
      step(0, 30, 0, 0, 0, 0, 0);
      step(0, 20, 0, 20, 0, 0, 0);
      step(0, 0, 2, 20, 0, 0, 0);
      step(0, 0, 3, 20, 0, 0, 0);
      step(0, 20, 0, 40, 0, 0, 0);
      step(0, 10, 0, 50, 0, 0, 0);
      step(0, 10, 1, 60, 0, 0, 0);
      step(0, 30, 1, 60, 0, 0, 0);
      step(0, 0, 0, 60, 0, 0, 0);
      // clear, then overflow
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 200, 0, 200, 0, 0, 0);
      step(0, 100, 0, 200, 0, 0, 0);
      step(0, 50, 0, 250, 0, 0, 0);
      step(0, 10, 0, 250, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      // inputs ignored while busy
      step(0, 200, 0, 200, 0, 0, 0);
      step(0, 0, 1, 150, 1, 0, 1);
      step(0, 50, 1, 150, 1, 0, 1);
      step(0, 50, 2, 150, 1, 0, 1);
      step(0, 0, 0, 150, 2, 150, 0);
      step(0, 50, 1, 150, 2, 150, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      // reset mid-CHANGE
      step(0, 100, 0, 100, 0, 0, 0);
      step(0, 0, 1, 50, 1, 0, 1);
      step(0, 0, 0, 50, 1, 0, 1);
      step(0, 0, 0, 50, 1, 0, 1);
      step(0, 0, 0, 50, 2, 50, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 10, 0, 10, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
